// File: rtl/switch_debounce_in.sv
// switch_debounce_in
// Synchronises and debounces a bank of board pushbuttons / DIP switches.
// Each channel has a four-state debounce FSM. It presents a clean pressed
// level plus single-cycle press, release and long-press pulses.

module switch_debounce_in #(
   parameter int NUM_IN          = 4,
   parameter int ACTIVE_LOW      = 1,
   parameter int DEBOUNCE_CYCLES = 532000,
   parameter int CNT_W           = 20,
   parameter int LONG_TICKS      = 100
) (
   input  logic              clk1,
   input  logic              rstn,
   input  logic [NUM_IN-1:0] sw_raw,
   output logic [NUM_IN-1:0] sw_level,
   output logic [NUM_IN-1:0] sw_press,
   output logic [NUM_IN-1:0] sw_release,
   output logic [NUM_IN-1:0] sw_long
);

   typedef enum logic [1:0] {
      RELEASED,
      CONFIRM_PRESS,
      PRESSED,
      CONFIRM_RELEASE
   } chanState_e;

   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0]        TICKS_LAST = 8'(LONG_TICKS);
   localparam logic [NUM_IN-1:0] RAW_IDLE   = (ACTIVE_LOW != 0) ? '1 : '0;

   logic [NUM_IN-1:0] syncMeta_q;
   logic [NUM_IN-1:0] syncOut_q;
   logic [NUM_IN-1:0] pressedNow;

   chanState_e        state_q [NUM_IN];
   logic [CNT_W-1:0]  cnt_q   [NUM_IN];
   logic [7:0]        ticks_q [NUM_IN];

   logic [NUM_IN-1:0] level_q;
   logic [NUM_IN-1:0] press_q;
   logic [NUM_IN-1:0] release_q;
   logic [NUM_IN-1:0] long_q;

   // Two-flop synchroniser. It idles at the unpressed pin level so that reset does not look like a press.
   always_ff @(posedge clk1 or negedge rstn) begin
      if (!rstn) begin
         syncMeta_q <= RAW_IDLE;
         syncOut_q  <= RAW_IDLE;
      end else begin
         syncMeta_q <= sw_raw;
         syncOut_q  <= syncMeta_q;
      end
   end

   // Normalise the pin polarity so that 1 always means pressed from here on.
   assign pressedNow = (ACTIVE_LOW != 0) ? ~syncOut_q : syncOut_q;

   // Per-channel debounce FSM. In PRESSED, cnt is reused as the long-press prescaler.
   always_ff @(posedge clk1 or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NUM_IN; i++) begin
            state_q[i] <= RELEASED;
            cnt_q[i]   <= '0;
            ticks_q[i] <= '0;
         end
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         long_q    <= '0;
      end else begin
         press_q   <= '0;
         release_q <= '0;
         long_q    <= '0;
         for (int i = 0; i < NUM_IN; i++) begin
            case (state_q[i])
               RELEASED: begin
                  if (pressedNow[i]) begin
                     state_q[i] <= CONFIRM_PRESS;
                     cnt_q[i]   <= '0;
                  end
               end
               CONFIRM_PRESS: begin
                  if (!pressedNow[i]) begin
                     state_q[i] <= RELEASED;
                  end else if (cnt_q[i] == CNT_LAST) begin
                     state_q[i] <= PRESSED;
                     level_q[i] <= 1'b1;
                     press_q[i] <= 1'b1;
                     cnt_q[i]   <= '0;
                     ticks_q[i] <= '0;
                  end else begin
                     cnt_q[i] <= cnt_q[i] + 1'b1;
                  end
               end
               PRESSED: begin
                  if (!pressedNow[i]) begin
                     state_q[i] <= CONFIRM_RELEASE;
                     cnt_q[i]   <= '0;
                  end else if (cnt_q[i] == CNT_LAST) begin
                     cnt_q[i] <= '0;
                     if (ticks_q[i] != TICKS_LAST) begin
                        ticks_q[i] <= ticks_q[i] + 8'd1;
                        if (ticks_q[i] + 8'd1 == TICKS_LAST) begin
                           long_q[i] <= 1'b1;
                        end
                     end
                  end else begin
                     cnt_q[i] <= cnt_q[i] + 1'b1;
                  end
               end
               CONFIRM_RELEASE: begin
                  if (pressedNow[i]) begin
                     state_q[i] <= PRESSED;
                     cnt_q[i]   <= '0;
                  end else if (cnt_q[i] == CNT_LAST) begin
                     state_q[i]   <= RELEASED;
                     level_q[i]   <= 1'b0;
                     release_q[i] <= 1'b1;
                     cnt_q[i]     <= '0;
                  end else begin
                     cnt_q[i] <= cnt_q[i] + 1'b1;
                  end
               end
               default: begin
                  state_q[i] <= RELEASED;
                  cnt_q[i]   <= '0;
               end
            endcase
         end
      end
   end

   assign sw_level   = level_q;
   assign sw_press   = press_q;
   assign sw_release = release_q;
   assign sw_long    = long_q;

endmodule

// File: tb/tb_switch_debounce_in.sv
// tb_switch_debounce_in
// Directed scenarios followed by random switch activity. The expected values
// come from a run-length reference model. A change is accepted once the
// synchronised input has disagreed with the current level for D+1
// consecutive edges.

module tb_switch_debounce_in;

   localparam int N = 4;
   localparam int D = 4;
   localparam int L = 3;

   logic         clk1;
   logic         rstn;
   logic [N-1:0] swRaw;
   logic [N-1:0] swLevel;
   logic [N-1:0] swPress;
   logic [N-1:0] swRelease;
   logic [N-1:0] swLong;

   int total;
   int bad;

   // Reference model state
   logic [N-1:0] mSyncA;
   logic [N-1:0] mSyncB;
   logic [N-1:0] mLevel;
   logic [N-1:0] mPress;
   logic [N-1:0] mRelease;
   logic [N-1:0] mLong;
   int           mRun   [N];
   int           mPre   [N];
   int           mTicks [N];

   // Pulse tallies taken from the DUT, used by scenario checks
   int evPress   [N];
   int evRelease [N];
   int evLong    [N];

   switch_debounce_in #(
      .NUM_IN          (N),
      .ACTIVE_LOW      (1),
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (3),
      .LONG_TICKS      (L)
   ) dut (
      .clk1       (clk1),
      .rstn       (rstn),
      .sw_raw     (swRaw),
      .sw_level   (swLevel),
      .sw_press   (swPress),
      .sw_release (swRelease),
      .sw_long    (swLong)
   );

   // Free-running 100 MHz clock
   initial begin
      clk1 = 1'b0;
      forever #5 clk1 = ~clk1;
   end

   task automatic modelReset();
      mSyncA   = '1;
      mSyncB   = '1;
      mLevel   = '0;
      mPress   = '0;
      mRelease = '0;
      mLong    = '0;
      for (int ch = 0; ch < N; ch++) begin
         mRun[ch]   = 0;
         mPre[ch]   = 0;
         mTicks[ch] = 0;
      end
   endtask

   task automatic clearTallies();
      for (int ch = 0; ch < N; ch++) begin
         evPress[ch]   = 0;
         evRelease[ch] = 0;
         evLong[ch]    = 0;
      end
   endtask

   // One rising edge of the reference model
   task automatic modelEdge();
      logic [N-1:0] sNow;
      sNow     = ~mSyncB;
      mPress   = '0;
      mRelease = '0;
      mLong    = '0;
      for (int ch = 0; ch < N; ch++) begin
         if (sNow[ch] != mLevel[ch]) begin
            mRun[ch]++;
            mPre[ch] = 0;
            if (mRun[ch] == D + 1) begin
               mLevel[ch] = sNow[ch];
               mRun[ch]   = 0;
               if (sNow[ch]) begin
                  mPress[ch] = 1'b1;
                  mTicks[ch] = 0;
               end else begin
                  mRelease[ch] = 1'b1;
               end
            end
         end else begin
            if (mLevel[ch] && mRun[ch] == 0) begin
               mPre[ch]++;
               if (mPre[ch] == D) begin
                  mPre[ch] = 0;
                  if (mTicks[ch] < L) begin
                     mTicks[ch]++;
                     if (mTicks[ch] == L) mLong[ch] = 1'b1;
                  end
               end
            end else begin
               mPre[ch] = 0;
            end
            mRun[ch] = 0;
         end
      end
      mSyncB = mSyncA;
      mSyncA = swRaw;
   endtask

   task automatic checkOutput(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkCount(input string tag, input int obs, input int exp);
      total++;
      assert (obs == exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drive one cycle of input just after a falling edge, clock it and compare all outputs at the next falling edge
   task automatic applyStimulus(input logic [N-1:0] raw);
      swRaw = raw;
      @(posedge clk1);
      modelEdge();
      @(negedge clk1);
      checkOutput("level",   swLevel,   mLevel);
      checkOutput("press",   swPress,   mPress);
      checkOutput("release", swRelease, mRelease);
      checkOutput("long",    swLong,    mLong);
      for (int ch = 0; ch < N; ch++) begin
         evPress[ch]   += int'(swPress[ch]);
         evRelease[ch] += int'(swRelease[ch]);
         evLong[ch]    += int'(swLong[ch]);
      end
   endtask

   task automatic repeatStimulus(input logic [N-1:0] raw, input int cycles);
      for (int k = 0; k < cycles; k++) applyStimulus(raw);
   endtask

   initial begin
      logic [N-1:0] rnd;
      total = 0;
      bad   = 0;
      rstn  = 1'b0;
      swRaw = 4'hF;
      modelReset();
      clearTallies();

      // Reset held with every pin at its idle level
      repeat (3) @(negedge clk1);
      checkOutput("rst_level", swLevel, 4'h0);
      checkOutput("rst_press", swPress, 4'h0);
      rstn = 1'b1;
      repeatStimulus(4'hF, 20);
      checkCount("rst_no_press", evPress[0] + evPress[1] + evPress[2] + evPress[3], 0);

      // Clean press and release on channel 0
      repeatStimulus(4'hE, 6);
      checkOutput("t2_no_early_press", swPress, 4'h0);
      applyStimulus(4'hE);
      checkOutput("t2_press_at_7", swPress, 4'h1);
      applyStimulus(4'hE);
      checkOutput("t2_press_one_cycle", swPress, 4'h0);
      checkOutput("t2_level", swLevel, 4'h1);
      repeatStimulus(4'hF, 7);
      checkOutput("t2_release_at_7", swRelease, 4'h1);
      checkOutput("t2_level_clear", swLevel, 4'h0);

      // Channel 1 bounces every two cycles, then settles pressed
      clearTallies();
      for (int k = 0; k < 20; k++) begin
         repeatStimulus((k % 2 == 0) ? 4'hD : 4'hF, 2);
      end
      checkCount("t3_bounce_no_press", evPress[1], 0);
      checkOutput("t3_bounce_level", swLevel, 4'h0);
      repeatStimulus(4'hD, 7);
      checkOutput("t3_settled_press", swPress, 4'h2);
      repeatStimulus(4'hD, 5);
      checkCount("t3_single_press", evPress[1], 1);

      // Long press on channel 2
      clearTallies();
      repeatStimulus(4'h9, 7);
      checkOutput("t4_press", swPress, 4'h4);
      repeatStimulus(4'h9, 12);
      checkOutput("t4_long_at_19", swLong, 4'h4);
      clearTallies();
      repeatStimulus(4'h9, 100);
      checkCount("t4_no_second_long", evLong[2], 0);
      repeatStimulus(4'hD, 2);
      repeatStimulus(4'h9, 10);
      checkCount("t4_bounce_no_release", evRelease[2], 0);
      checkCount("t4_bounce_no_press", evPress[2], 0);

      // All channels together
      repeatStimulus(4'hF, 10);
      checkOutput("t5_all_released", swLevel, 4'h0);
      repeatStimulus(4'h0, 7);
      checkOutput("t5_press_all", swPress, 4'hF);
      repeatStimulus(4'h9, 7);
      checkOutput("t5_release_0_3", swRelease, 4'h9);
      checkOutput("t5_level_1_2", swLevel, 4'h6);

      // Reset pulse while channel 0 is held
      repeatStimulus(4'h8, 8);
      checkOutput("t6_level_before", swLevel, 4'h7);
      rstn = 1'b0;
      #1;
      checkOutput("t6_async_level", swLevel, 4'h0);
      checkOutput("t6_no_release", swRelease, 4'h0);
      modelReset();
      @(posedge clk1);
      @(negedge clk1);
      rstn = 1'b1;
      repeatStimulus(4'h8, 6);
      checkOutput("t6_no_early_press", swPress, 4'h0);
      applyStimulus(4'h8);
      checkOutput("t6_fresh_press", swPress, 4'h7);

      // Random switch activity against the model
      rnd = 4'hF;
      for (int k = 0; k < 1500; k++) begin
         for (int ch = 0; ch < N; ch++) begin
            if ($urandom_range(5) == 0) rnd[ch] = ~rnd[ch];
         end
         applyStimulus(rnd);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
